// File: rtl/id_scoreboard.sv
// Register-latency scoreboard for the decode stage.
// Each tracked register has a down-counter holding the cycles left until its
// pending result can be forwarded. Readers of a busy register and writes that
// would finish before an older pending write raise a combinational stall request.
module id_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned NRP  = 2,
  parameter int unsigned CW   = 3,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_waddr,
  input  logic [CW-1:0]     issue_lat,
  input  logic [NRP-1:0]    rd_valid,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic              stallreq,
  output logic [NREG-1:0]   busy,
  output logic [15:0]       stall_cnt
);

  // Register 0 is hardwired zero, so it has no counter at all.
  // Addresses at or above NREG never match an index below, which makes
  // out-of-range registers untracked without any explicit range compare.
  logic [CW-1:0] cnt_q [1:NREG-1];
  logic          raw_hit;
  logic          waw_hit;
  logic          issue_acc;

  // Hazard detection against registered counter state and current inputs.
  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      for (int unsigned i = 0; i < NRP; i++) begin
        if (rd_valid[i] && (rd_addr[i*AW +: AW] == AW'(r)) && (cnt_q[r] != '0))
          raw_hit = 1'b1;
      end
      if (issue_valid && (issue_waddr == AW'(r)) && (cnt_q[r] > issue_lat))
        waw_hit = 1'b1;
    end
    stallreq  = raw_hit | waw_hit;
    issue_acc = issue_valid & ~stall & ~stallreq;
  end

  // Busy vector mirrors only the registered counters.
  always_comb begin
    busy    = '0;
    for (int unsigned r = 1; r < NREG; r++)
      busy[r] = (cnt_q[r] != '0);
  end

  // Counters drain every cycle (even under external stall); an accepted issue
  // reloads its destination, taking priority over that register's decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 1; r < NREG; r++)
        cnt_q[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (issue_acc && (issue_waddr == AW'(r)))
          cnt_q[r] <= issue_lat;
        else if (cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - 1'b1;
      end
    end
  end

  // Saturating count of cycles spent requesting a hazard stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (stallreq && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus randomized
// traffic compared against a per-register cycles-remaining model.
module tb_id_scoreboard;

  localparam int unsigned NREG = 24;   // non power of two: addresses 24..31 are untracked
  localparam int unsigned NRP  = 2;
  localparam int unsigned CW   = 3;
  localparam int unsigned AW   = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  logic              issue_valid = 1'b0;
  logic [AW-1:0]     issue_waddr = '0;
  logic [CW-1:0]     issue_lat = '0;
  logic [NRP-1:0]    rd_valid = '0;
  logic [NRP*AW-1:0] rd_addr = '0;
  logic              stallreq;
  logic [NREG-1:0]   busy;
  logic [15:0]       stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: cycles remaining per register, and stall cycle tally.
  int mcnt [NREG];
  int mscnt;

  id_scoreboard #(.NREG(NREG), .NRP(NRP), .CW(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr), .issue_lat(issue_lat),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .stallreq(stallreq), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit tracked(input int a);
    return (a != 0) && (a < NREG);
  endfunction

  function automatic bit exp_sr();
    bit h = 0;
    for (int i = 0; i < NRP; i++) begin
      int a = int'(rd_addr[i*AW +: AW]);
      if (rd_valid[i] && tracked(a) && mcnt[a] > 0) h = 1;
    end
    if (issue_valid && tracked(int'(issue_waddr)) && mcnt[issue_waddr] > int'(issue_lat)) h = 1;
    return h;
  endfunction

  function automatic logic [NREG-1:0] exp_busy();
    logic [NREG-1:0] b = '0;
    for (int r = 0; r < NREG; r++) b[r] = (mcnt[r] > 0);
    return b;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    mscnt = 0;
  endfunction

  task automatic drive(input logic st, input logic iv, input int wa, input int lat,
                       input logic [1:0] rv, input int ra0, input int ra1);
    stall       = st;
    issue_valid = iv;
    issue_waddr = AW'(wa);
    issue_lat   = CW'(lat);
    rd_valid    = rv;
    rd_addr     = {AW'(ra1), AW'(ra0)};
    #1;
  endtask

  // Advance one clock and move the model forward with the inputs in force.
  task automatic tick();
    bit sr  = exp_sr();
    bit acc = issue_valid && !stall && !sr && tracked(int'(issue_waddr));
    int wa  = int'(issue_waddr);
    int lat = int'(issue_lat);
    @(posedge clk);
    for (int r = 0; r < NREG; r++) if (mcnt[r] > 0) mcnt[r]--;
    if (acc) mcnt[wa] = lat;
    if (sr && mscnt < 65535) mscnt++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    // Hazard-shaped inputs while in reset: state is zero, so no stall.
    drive(0, 1, 7, 2, 2'b11, 7, 3);
    vectors++;
    if (stallreq !== 1'b0) begin miscompares++; $display("FAIL reset_stallreq: got %b expected 0", stallreq); end
    vectors++;
    if (busy !== '0) begin miscompares++; $display("FAIL reset_busy: got %h expected 0", busy); end
    vectors++;
    if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 1, 8, 1, 2'b00, 0, 0);
    vectors++;
    if (stallreq !== 1'b0) begin miscompares++; $display("FAIL load_use_issue: got %b expected 0", stallreq); end
    tick();
    drive(0, 0, 0, 0, 2'b01, 8, 0);
    vectors++;
    if (stallreq !== 1'b1) begin miscompares++; $display("FAIL load_use_stall: got %b expected 1", stallreq); end
    tick();
    drive(0, 0, 0, 0, 2'b01, 8, 0);
    vectors++;
    if (stallreq !== 1'b0) begin miscompares++; $display("FAIL load_use_release: got %b expected 0", stallreq); end
    vectors++;
    if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt); end
    tick();
  endtask

  task automatic test_multicycle();
    drive(0, 1, 5, 4, 2'b00, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, 2'b10, 0, 5);
      vectors++;
      if (stallreq !== (k < 4)) begin miscompares++; $display("FAIL multicycle_stall[%0d]: got %b expected %b", k, stallreq, k < 4); end
      vectors++;
      if (busy[5] !== (k < 4)) begin miscompares++; $display("FAIL multicycle_busy5[%0d]: got %b expected %b", k, busy[5], k < 4); end
      tick();
    end
  endtask

  task automatic test_dual_port_same_reg();
    do_reset();
    drive(0, 1, 12, 2, 2'b00, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 2'b11, 12, 12);
      tick();
    end
    vectors++;
    if (stall_cnt !== 16'd2) begin miscompares++; $display("FAIL dual_port_stall_cnt: got %0d expected 2", stall_cnt); end
  endtask

  task automatic test_waw();
    drive(0, 1, 3, 5, 2'b00, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 3, 1, 2'b00, 0, 0);
      vectors++;
      if (stallreq !== (k < 4)) begin miscompares++; $display("FAIL waw_stall[%0d]: got %b expected %b", k, stallreq, k < 4); end
      tick();
    end
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    vectors++;
    if (busy[3] !== 1'b1) begin miscompares++; $display("FAIL waw_reload: got %b expected 1", busy[3]); end
    tick();
    vectors++;
    if (busy[3] !== 1'b0) begin miscompares++; $display("FAIL waw_drain: got %b expected 0", busy[3]); end
  endtask

  task automatic test_zero_reg();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 7, 2'b11, 0, 0);
      vectors++;
      if (stallreq !== 1'b0) begin miscompares++; $display("FAIL zero_reg_stall[%0d]: got %b expected 0", k, stallreq); end
      vectors++;
      if (busy !== '0) begin miscompares++; $display("FAIL zero_reg_busy[%0d]: got %h expected 0", k, busy); end
      tick();
    end
  endtask

  task automatic test_lat_zero();
    drive(0, 1, 14, 0, 2'b00, 0, 0);
    tick();
    drive(0, 0, 0, 0, 2'b11, 14, 14);
    vectors++;
    if (stallreq !== 1'b0) begin miscompares++; $display("FAIL lat_zero_stall: got %b expected 0", stallreq); end
    vectors++;
    if (busy[14] !== 1'b0) begin miscompares++; $display("FAIL lat_zero_busy: got %b expected 0", busy[14]); end
    tick();
  endtask

  task automatic test_ext_stall();
    drive(0, 1, 9, 3, 2'b00, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 10, 2, 2'b00, 0, 0);
      vectors++;
      if (busy[9] !== (k < 3)) begin miscompares++; $display("FAIL ext_stall_busy9[%0d]: got %b expected %b", k, busy[9], k < 3); end
      tick();
    end
    drive(0, 0, 0, 0, 2'b01, 9, 0);
    vectors++;
    if (stallreq !== 1'b0) begin miscompares++; $display("FAIL ext_stall_reader: got %b expected 0", stallreq); end
    vectors++;
    if (busy[10] !== 1'b0) begin miscompares++; $display("FAIL ext_stall_no_issue: got %b expected 0", busy[10]); end
    tick();
  endtask

  task automatic test_out_of_range();
    drive(0, 1, 26, 5, 2'b11, 25, 30);
    vectors++;
    if (stallreq !== 1'b0) begin miscompares++; $display("FAIL oor_issue_stall: got %b expected 0", stallreq); end
    tick();
    drive(0, 1, 26, 0, 2'b11, 26, 31);
    vectors++;
    if (stallreq !== 1'b0) begin miscompares++; $display("FAIL oor_reader_stall: got %b expected 0", stallreq); end
    vectors++;
    if (busy !== '0) begin miscompares++; $display("FAIL oor_busy: got %h expected 0", busy); end
    tick();
  endtask

  task automatic test_async_reset();
    drive(0, 1, 4, 6, 2'b00, 0, 0);
    tick();
    drive(0, 0, 0, 0, 2'b01, 4, 0);
    vectors++;
    if (busy[4] !== 1'b1) begin miscompares++; $display("FAIL async_pre_busy4: got %b expected 1", busy[4]); end
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (busy !== '0) begin miscompares++; $display("FAIL async_busy: got %h expected 0", busy); end
    vectors++;
    if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL async_stall_cnt: got %0d expected 0", stall_cnt); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 1, 4, 2, 2'b01, 4, 0);
    vectors++;
    if (stallreq !== 1'b0) begin miscompares++; $display("FAIL async_reader: got %b expected 0", stallreq); end
    tick();
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    vectors++;
    if (busy[4] !== 1'b1) begin miscompares++; $display("FAIL async_first_issue: got %b expected 1", busy[4]); end
    tick();
  endtask

  // Addresses mostly from a small pool so hazards are frequent, with an
  // occasional untracked address above NREG-1.
  function automatic int rand_addr();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(NREG, 31));
    return int'($urandom_range(0, 6));
  endfunction

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [NREG-1:0] eb;
      bit es;
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, rand_addr(),
            int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), rand_addr(), rand_addr());
      es = exp_sr();
      eb = exp_busy();
      vectors++;
      if (stallreq !== es) begin miscompares++; $display("FAIL random_stallreq[%0d]: got %b expected %b", k, stallreq, es); end
      vectors++;
      if (busy !== eb) begin miscompares++; $display("FAIL random_busy[%0d]: got %h expected %h", k, busy, eb); end
      vectors++;
      if (stall_cnt !== 16'(mscnt)) begin miscompares++; $display("FAIL random_stall_cnt[%0d]: got %0d expected %0d", k, stall_cnt, mscnt); end
      tick();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_use();
    test_multicycle();
    test_dual_port_same_reg();
    test_waw();
    test_zero_reg();
    test_lat_zero();
    test_ext_stall();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers tracked; register 0 is hardwired zero.
REQ-002 Parameter NRP, default 2: number of decode-stage source-operand read ports checked per cycle.
REQ-003 Parameter CW, default 3: width of per-register latency counter; maximum latency 2^CW-1.
REQ-004 Derived AW = clog2(NREG), not user-settable.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  decode stage held by a downstream stall; no issue accepted while high.
REQ-008 issue_valid  in  1  decode holds an instruction that writes a register.
REQ-009 issue_waddr  in  AW  destination register of that instruction.
REQ-010 issue_lat  in  CW  cycles after issue before result is forwardable; 0 = ALU, 1 = load, >1 = multi-cycle unit.
REQ-011 rd_valid  in  NRP  per-port source-operand-used flag.
REQ-012 rd_addr  in  NRP*AW  per-port source register, port i at bits [i*AW +: AW].
REQ-013 stallreq  out  1  combinational hazard stall request to the stall controller.
REQ-014 busy  out  NREG  bit r high when register r counter is nonzero.
REQ-015 stall_cnt  out  16  registered count of cycles stallreq was high, saturating.

Function
REQ-016 Per register r (1..NREG-1), one CW-bit counter cnt[r]; cnt[0] constant 0, never written.
REQ-017 Issue accepted in a cycle iff issue_valid & ~stall & ~stallreq & issue_waddr != 0.
REQ-018 Each edge, every nonzero cnt[r] decrements by 1; zero counters hold.
REQ-019 On accepted issue, cnt[issue_waddr] loads issue_lat, overriding that register's decrement the same edge.
REQ-020 RAW hazard: port i hazards when rd_valid[i] & rd_addr[i] != 0 & cnt[rd_addr[i]] != 0.
REQ-021 WAW hazard: issue_valid & issue_waddr != 0 & cnt[issue_waddr] > issue_lat.
REQ-022 stallreq = OR of all RAW port hazards OR WAW hazard; purely combinational from current state and inputs.
REQ-023 Timing: issue at edge T with lat L -> dependent reader stalls while cnt != 0, i.e. exactly L cycles, proceeds in cycle L after issue.
REQ-024 stall input does not freeze counters; downstream units keep retiring while decode is held.
REQ-025 Issue with issue_lat 0 leaves cnt at 0; no stall generated for any reader.
REQ-026 Both read ports naming the same busy register produce one stall, no double counting.
REQ-027 Out-of-range rd_addr/issue_waddr (>= NREG) treated as not tracked: no hazard, no write.
REQ-028 stall_cnt increments by 1 each edge where stallreq is high; holds at 16'hFFFF.
REQ-029 busy reflects registered counter state only, not same-cycle issue.

Reset
REQ-030 rst low asynchronously clears every cnt[r] to 0 and stall_cnt to 0, regardless of clk.
REQ-031 During reset: busy = 0, stallreq depends only on inputs against zero state, hence 0.
REQ-032 Reset asserted mid-countdown discards all pending entries; first cycle after release accepts issues normally.

Verification
REQ-033 Load-use: issue waddr=8 lat=1, next cycle rd_addr[0]=8 rd_valid=01 -> stallreq=1 for 1 cycle, 0 the following cycle, stall_cnt=1.
REQ-034 Multi-cycle: issue waddr=5 lat=4, reader on port 1 of r5 -> stallreq high 4 consecutive cycles, busy[5] falls with it.
REQ-035 WAW: r3 pending cnt=5, issue waddr=3 lat=1 -> stallreq=1 until cnt[3]<=1, then issue accepted, cnt[3]=1.
REQ-036 Zero register: issue waddr=0 lat=7, reader rd_addr=0 -> stallreq=0, busy=0 throughout.
REQ-037 External stall: issue r9 lat=3 then stall=1 for 5 cycles -> cnt[9] reaches 0 after 3 cycles, no new issue accepted, reader of r9 after release not stalled.
REQ-038 Async reset: pull rst low between edges with r4 cnt=6 -> busy=0 immediately, stall_cnt=0; after release reader of r4 sees no stall.
